// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution. It evaluates each branch condition and, on a
// mispredict, sends a redirect to fetch and then holds a fixed-length flush.
module branch_resolve_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       br_funct3_i,
  input  logic             zflag_i,
  input  logic             sflag_i,
  input  logic             cflag_i,
  input  logic             br_pred_taken_i,
  input  logic [31:0]      br_pc_i,
  input  logic [31:0]      br_target_i,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             stall_o,
  output logic             illegal_br_o,
  output logic [CNT_W-1:0] mispredict_cnt_o,
  output logic [1:0]       state_o
);

  // Handshakes (br_valid/br_ready and redirect_valid/redirect_ready): a transfer
  // happens on a rising edge where valid and ready are both high. The source
  // holds valid and its payload stable until that edge, and never drops valid early.

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      rpc_q, rpc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             taken, illegal_f3, accept, mispredict;
  logic [31:0]      seq_pc, correct_pc;

  always_comb begin
    taken      = 1'b0;
    illegal_f3 = 1'b0;
    case (br_funct3_i)
      3'b000:  taken = zflag_i;
      3'b001:  taken = ~zflag_i;
      3'b100:  taken = sflag_i;
      3'b101:  taken = ~sflag_i;
      3'b110:  taken = cflag_i;
      3'b111:  taken = ~cflag_i;
      default: illegal_f3 = 1'b1;
    endcase
  end

  // The fall-through address wraps modulo 2^32.
  assign seq_pc     = br_pc_i + 32'd4;
  assign correct_pc = taken ? br_target_i : seq_pc;
  assign accept     = br_valid_i & (state_q == S_IDLE);
  assign mispredict = taken ^ br_pred_taken_i;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    rpc_d     = rpc_q;
    cnt_d     = cnt_q;
    illegal_d = accept & illegal_f3;
    case (state_q)
      S_IDLE: begin
        if (accept && mispredict) begin
          rpc_d = correct_pc;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready_i) begin
          fcnt_d  = FLUSH_LOAD;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 4'd0) state_d = S_IDLE;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      fcnt_q    <= 4'd0;
      rpc_q     <= 32'd0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      rpc_q     <= rpc_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // br_ready is held low while reset is asserted so every output reads 0 in reset.
  assign br_ready_o       = rst_ni & (state_q == S_IDLE);
  assign redirect_valid_o = (state_q == S_REDIRECT);
  assign flush_o          = (state_q == S_FLUSH);
  assign stall_o          = (state_q != S_IDLE);
  assign redirect_pc_o    = rpc_q;
  assign illegal_br_o     = illegal_q;
  assign mispredict_cnt_o = cnt_q;
  assign state_o          = state_q;

endmodule
